apb_master: RTL and testbench

- APB requester bridge. Accepts single read/write requests from an on-chip initiator over a valid/ready handshake and drives them onto APB as SETUP/ACCESS transfers.
- Returns read data and completion status to the initiator.
- Sits between the system interconnect and the APB peripheral segment.
- Pairs with the team's apb_slave request interface: the same addr / rd0_wr1 / wr_data / rd_valid / rd_data signal set, seen from the initiator side.

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_master_if.sv | 46 ++++
 rtl/apb_timeout_cnt.sv | 37 +++
 rtl/apb_master.sv | 138 +++++++++++++
 tb/tb_apb_master.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM states, default bus widths and
// transfer-direction encodings common to apb_master and apb_slave.
package apb_pkg;

   localparam int unsigned APB_ADDR_WIDTH = 32;
   localparam int unsigned APB_DATA_WIDTH = 32;

   // Direction encoding on rd0_wr1 / pwrite.
   localparam logic APB_RD = 1'b0;
   localparam logic APB_WR = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_mst_state_t;

endpackage

// File: rtl/apb_master_if.sv
// Initiator request channel plus APB requester bus of the apb_master bridge.
// The master modport is the bridge's view; the slave modport is the
// environment (initiator + APB peripheral) view.
interface apb_master_if
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH
);

   // initiator side
   logic                  i_valid;
   logic                  o_ready;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_rd0_wr1;
   logic [DATA_WIDTH-1:0] i_wr_data;
   logic                  o_rd_valid;
   logic [DATA_WIDTH-1:0] o_rd_data;
   logic                  o_done;
   logic                  o_err;

   // APB side
   logic                  o_psel;
   logic                  o_penable;
   logic                  o_pwrite;
   logic [ADDR_WIDTH-1:0] o_paddr;
   logic [DATA_WIDTH-1:0] o_pwdata;
   logic [DATA_WIDTH-1:0] i_prdata;
   logic                  i_pready;
   logic                  i_pslverr;

   modport master (
      input  i_valid, i_addr, i_rd0_wr1, i_wr_data,
      input  i_prdata, i_pready, i_pslverr,
      output o_ready, o_rd_valid, o_rd_data, o_done, o_err,
      output o_psel, o_penable, o_pwrite, o_paddr, o_pwdata
   );

   modport slave (
      output i_valid, i_addr, i_rd0_wr1, i_wr_data,
      output i_prdata, i_pready, i_pslverr,
      input  o_ready, o_rd_valid, o_rd_data, o_done, o_err,
      input  o_psel, o_penable, o_pwrite, o_paddr, o_pwdata
   );

endinterface

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS-phase wait counter. o_expired flags the last permitted
// wait cycle; it is tied low when TIMEOUT_CYCLES = 0 (timeout disabled).
module apb_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic i_clk_apb,
   input  logic i_rstn_apb,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int unsigned CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int unsigned LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CW-1:0] LAST   = CW'(LAST_INT);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: clear has priority, increment saturates at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_en && (cnt_q != '1)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register.
   always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
      if (!i_rstn_apb) cnt_q <= '0;
      else             cnt_q <= cnt_d;
   end

   assign o_expired = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester bridge: takes one valid/ready request at a time, runs it as
// an APB SETUP/ACCESS transfer, and reports completion, error and read data.
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        i_clk_apb,
   input  logic        i_rstn_apb,
   apb_master_if.master bus
);

   apb_mst_state_t        state_q, state_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  cnt_clr, cnt_en, cnt_expired;

   apb_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .i_clk_apb  (i_clk_apb),
      .i_rstn_apb (i_rstn_apb),
      .i_clr      (cnt_clr),
      .i_en       (cnt_en),
      .o_expired  (cnt_expired)
   );

   // Next-state and registered-output logic for the IDLE/SETUP/ACCESS FSM.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      psel_d     = psel_q;
      penable_d  = penable_q;
      pwrite_d   = pwrite_q;
      paddr_d    = paddr_q;
      pwdata_d   = pwdata_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.i_valid) begin
               paddr_d  = bus.i_addr;
               pwrite_d = (bus.i_rd0_wr1 == APB_WR);
               pwdata_d = bus.i_wr_data;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            cnt_clr   = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (bus.i_pready) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               done_d    = 1'b1;
               err_d     = bus.i_pslverr;
               state_d   = IDLE;
               if (pwrite_q == APB_RD) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = bus.i_prdata;
               end
            end else if (cnt_expired) begin
               // Peripheral never answered: abort and report an error.
               psel_d    = 1'b0;
               penable_d = 1'b0;
               done_d    = 1'b1;
               err_d     = 1'b1;
               state_d   = IDLE;
               if (pwrite_q == APB_RD) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = '0;
               end
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset drops the bus immediately.
   always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!i_rstn_apb) begin
         state_q    <= IDLE;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         paddr_q    <= '0;
         pwdata_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         psel_q     <= psel_d;
         penable_q  <= penable_d;
         pwrite_q   <= pwrite_d;
         paddr_q    <= paddr_d;
         pwdata_q   <= pwdata_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign bus.o_ready    = (state_q == IDLE);
   assign bus.o_psel     = psel_q;
   assign bus.o_penable  = penable_q;
   assign bus.o_pwrite   = pwrite_q;
   assign bus.o_paddr    = paddr_q;
   assign bus.o_pwdata   = pwdata_q;
   assign bus.o_rd_data  = rd_data_q;
   assign bus.o_rd_valid = rd_valid_q;
   assign bus.o_done     = done_q;
   assign bus.o_err      = err_q;

endmodule

// File: tb/tb_apb_master.sv
// Randomized scoreboard bench for apb_master: a driver issues requests and
// queues the expected completion, an APB responder model answers with a
// chosen number of wait states, and a monitor checks each completion.
module tb_apb_master;

   localparam int unsigned T = 4;   // TIMEOUT_CYCLES under test

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      int          w;        // wait cycles before pready (>= T means never)
      logic        slverr;
      logic [31:0] prdata;
      int          gap;      // idle cycles after acceptance
   } req_t;

   typedef struct {
      logic        wr;
      logic        err;
      logic [31:0] rd_data;
      int          done_cyc;
   } exp_t;

   logic i_clk_apb  = 1'b0;
   logic i_rstn_apb = 1'b0;
   int   errors     = 0;
   int   checks     = 0;
   int   cyc        = 0;
   logic slv_en     = 1'b1;

   req_t slv_q[$];
   exp_t exp_q[$];

   apb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   apb_master #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .i_clk_apb  (i_clk_apb),
      .i_rstn_apb (i_rstn_apb),
      .bus        (bus)
   );

   always #5 i_clk_apb = ~i_clk_apb;
   always @(posedge i_clk_apb) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic req_t mk_req(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                   input int w, input logic slverr, input logic [31:0] prdata, input int gap);
      req_t r;
      r.addr = addr; r.wr = wr; r.wdata = wdata; r.w = w;
      r.slverr = slverr; r.prdata = prdata; r.gap = gap;
      return r;
   endfunction

   // Reference model: what the initiator should see for a request accepted
   // on edge acc, given how the peripheral will respond.
   function automatic exp_t model(input req_t r, input int acc);
      exp_t e;
      bool_timeout: begin end
      e.wr = r.wr;
      if (r.w >= int'(T)) begin
         e.err      = 1'b1;
         e.rd_data  = 32'h0;
         e.done_cyc = acc + 1 + int'(T);      // 1 SETUP + T ACCESS cycles
      end else begin
         e.err      = r.slverr;
         e.rd_data  = r.prdata;
         e.done_cyc = acc + 1 + r.w + 1;      // 1 SETUP + (w+1) ACCESS cycles
      end
      return e;
   endfunction

   // Initiator driver: presents a request (garbage while the bridge is busy),
   // queues expectations at the accepting edge, then idles for r.gap cycles.
   task automatic drive_req(input req_t r);
      int budget = 0;
      bus.i_valid = 1'b1;
      while (!bus.o_ready) begin
         bus.i_addr    = $urandom;
         bus.i_wr_data = $urandom;
         bus.i_rd0_wr1 = 1'($urandom_range(0, 1));
         @(negedge i_clk_apb);
         budget++;
         if (budget > 50) begin
            check("accept_timeout", 64'(bus.o_ready), 64'd1);
            return;
         end
      end
      bus.i_addr    = r.addr;
      bus.i_rd0_wr1 = r.wr;
      bus.i_wr_data = r.wdata;
      exp_q.push_back(model(r, cyc + 1));
      slv_q.push_back(r);
      @(posedge i_clk_apb);
      @(negedge i_clk_apb);
      if (r.gap > 0) begin
         bus.i_valid   = 1'b0;
         bus.i_addr    = $urandom;
         bus.i_wr_data = $urandom;
         repeat (r.gap) @(negedge i_clk_apb);
      end
   endtask

   // APB peripheral model: checks the SETUP/ACCESS sequence and address
   // stability, and answers after the requested number of wait states.
   initial begin
      req_t s;
      bus.i_pready  = 1'b0;
      bus.i_pslverr = 1'b0;
      bus.i_prdata  = '0;
      forever begin
         @(negedge i_clk_apb);
         if (slv_en && i_rstn_apb && bus.o_psel && !bus.o_penable) begin
            if (slv_q.size() == 0) begin
               check("unexpected_setup", 64'(bus.o_psel), 64'd0);
            end else begin
               s = slv_q.pop_front();
               check("setup_paddr", 64'(bus.o_paddr), 64'(s.addr));
               check("setup_pwrite", 64'(bus.o_pwrite), 64'(s.wr));
               if (s.wr) check("setup_pwdata", 64'(bus.o_pwdata), 64'(s.wdata));
               for (int k = 0; k < int'(T); k++) begin
                  @(negedge i_clk_apb);
                  check("access_psel_penable", {62'd0, bus.o_psel, bus.o_penable}, 64'd3);
                  check("access_paddr_stable", 64'(bus.o_paddr), 64'(s.addr));
                  check("access_pwrite_stable", 64'(bus.o_pwrite), 64'(s.wr));
                  if (s.wr) check("access_pwdata_stable", 64'(bus.o_pwdata), 64'(s.wdata));
                  if (k == s.w) begin
                     bus.i_pready  = 1'b1;
                     bus.i_prdata  = s.prdata;
                     bus.i_pslverr = s.slverr;
                     break;
                  end
                  bus.i_pready  = 1'b0;
                  bus.i_prdata  = $urandom;
                  bus.i_pslverr = 1'($urandom_range(0, 1));
               end
               @(negedge i_clk_apb);
               bus.i_pready  = 1'b0;
               bus.i_pslverr = 1'b0;
               bus.i_prdata  = $urandom;
               check("bus_released", {62'd0, bus.o_psel, bus.o_penable}, 64'd0);
            end
         end
      end
   end

   // Completion monitor: pops the scoreboard on every o_done.
   logic done_prev = 1'b0, rdv_prev = 1'b0, err_prev = 1'b0;
   always @(negedge i_clk_apb) begin
      exp_t e;
      if (!i_rstn_apb) begin
         done_prev = 1'b0; rdv_prev = 1'b0; err_prev = 1'b0;
      end else begin
         check("ready_is_not_psel", 64'(bus.o_ready), 64'(!bus.o_psel));
         check("pulse_width", {61'd0, bus.o_done & done_prev, bus.o_rd_valid & rdv_prev,
                               bus.o_err & err_prev}, 64'd0);
         if (bus.o_done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 64'(bus.o_done), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("done_cycle", 64'(cyc), 64'(e.done_cyc));
               check("done_err", 64'(bus.o_err), 64'(e.err));
               check("done_rd_valid", 64'(bus.o_rd_valid), 64'(!e.wr));
               if (!e.wr) check("rd_data", 64'(bus.o_rd_data), 64'(e.rd_data));
               check("ready_at_done", 64'(bus.o_ready), 64'd1);
            end
         end else begin
            check("no_stray_pulse", {62'd0, bus.o_rd_valid, bus.o_err}, 64'd0);
         end
         done_prev = bus.o_done; rdv_prev = bus.o_rd_valid; err_prev = bus.o_err;
      end
   end

   task automatic drain(input string name);
      int budget = 0;
      while (exp_q.size() != 0 && budget < 200) begin
         @(negedge i_clk_apb);
         budget++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      req_t r;
      bus.i_valid   = 1'b0;
      bus.i_addr    = '0;
      bus.i_rd0_wr1 = 1'b0;
      bus.i_wr_data = '0;

      // Reset values.
      #2;
      check("rst_ready", 64'(bus.o_ready), 64'd1);
      check("rst_psel", 64'(bus.o_psel), 64'd0);
      check("rst_penable", 64'(bus.o_penable), 64'd0);
      check("rst_pwrite", 64'(bus.o_pwrite), 64'd0);
      check("rst_paddr", 64'(bus.o_paddr), 64'd0);
      check("rst_pwdata", 64'(bus.o_pwdata), 64'd0);
      check("rst_rd_data", 64'(bus.o_rd_data), 64'd0);
      check("rst_pulses", {61'd0, bus.o_done, bus.o_rd_valid, bus.o_err}, 64'd0);
      repeat (3) @(negedge i_clk_apb);
      i_rstn_apb = 1'b1;
      @(negedge i_clk_apb);

      // Idle with i_valid low: no APB activity.
      repeat (4) begin
         @(negedge i_clk_apb);
         check("idle_no_psel", 64'(bus.o_psel), 64'd0);
      end

      // Directed cases.
      drive_req(mk_req(32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 2));
      drive_req(mk_req(32'h0000_0040, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678, 2));
      drive_req(mk_req(32'h0000_0044, 1'b0, 32'h0, 0, 1'b1, 32'hA5A5_A5A5, 2));
      drive_req(mk_req(32'h0000_0048, 1'b0, 32'h0, 9, 1'b0, 32'hFFFF_FFFF, 2));
      drive_req(mk_req(32'h0000_0050, 1'b1, 32'h0BAD_F00D, 9, 1'b0, 32'h0, 2));
      drive_req(mk_req(32'h0000_2000, 1'b1, 32'h1111_1111, 0, 1'b0, 32'h0, 0));
      drive_req(mk_req(32'h0000_2004, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 0));
      drive_req(mk_req(32'h0000_2008, 1'b0, 32'h0, int'(T) - 1, 1'b0, 32'h5555_AAAA, 2));

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         r = mk_req($urandom, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 6)),
                    1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 2)));
         drive_req(r);
      end
      bus.i_valid = 1'b0;
      drain("drain_random");

      // Reset during ACCESS: the transfer is lost and the bus drops at once.
      @(negedge i_clk_apb);
      slv_en        = 1'b0;
      bus.i_pready  = 1'b0;
      bus.i_valid   = 1'b1;
      bus.i_rd0_wr1 = 1'b1;
      bus.i_addr    = 32'h0000_3000;
      bus.i_wr_data = 32'h7777_7777;
      @(negedge i_clk_apb);                 // SETUP
      bus.i_valid = 1'b0;
      @(negedge i_clk_apb);                 // ACCESS
      check("pre_rst_access", {62'd0, bus.o_psel, bus.o_penable}, 64'd3);
      #1 i_rstn_apb = 1'b0;
      #1;
      check("mid_rst_bus_drop", {62'd0, bus.o_psel, bus.o_penable}, 64'd0);
      check("mid_rst_ready", 64'(bus.o_ready), 64'd1);
      check("mid_rst_paddr", 64'(bus.o_paddr), 64'd0);
      @(negedge i_clk_apb);
      check("mid_rst_no_done", 64'(bus.o_done), 64'd0);
      i_rstn_apb = 1'b1;
      @(negedge i_clk_apb);
      check("post_rst_ready", 64'(bus.o_ready), 64'd1);
      slv_en = 1'b1;
      drive_req(mk_req(32'h0000_3004, 1'b1, 32'h8888_8888, 0, 1'b0, 32'h0, 3));
      bus.i_valid = 1'b0;
      drain("drain_post_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
